i2c_bus_arbiter: RTL and testbench

- Two-requester transaction controller that sequences the shared I2C_MASTER engine; the I2C_SLAVE side is unaffected.
- Each requester posts a single-register transaction: write (device, register, one data byte) or read (device, register, one returned byte).
- The block arbitrates round-robin, drives the master's start/datasend handshake, collects the read byte, and reports done or error per requester with a watchdog timeout.
- Sits between system logic and I2C_MASTER.

---
 rtl/i2c_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - two-requester round-robin sequencer for a shared I2C master engine
// Each grant runs one register write or read through the master handshake, guarded by a watchdog.
module i2c_bus_arbiter #(
   parameter int TIMEOUT = 65535,
   parameter int TW      = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_rw,
   input  logic [13:0] req_dev,
   input  logic [15:0] req_reg,
   input  logic [15:0] req_wdata,
   output logic [1:0]  grant,
   output logic [1:0]  req_done,
   output logic [1:0]  req_err,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic        m_start,
   input  logic        m_ready,
   input  logic        m_send,
   input  logic        m_sended,
   input  logic        m_receive,
   input  logic        m_received,
   output logic [7:0]  m_datasend,
   input  logic [7:0]  m_datareceive
);

   typedef enum logic [2:0] {
      IDLE, START, ADDR, REG, DATA, STOP, RECOVER, DONE
   } state_t;

   state_t        state;
   logic          last;
   logic          err;
   logic [TW-1:0] timer;
   logic [6:0]    dev_q;
   logic          rw_q;
   logic [7:0]    reg_q;
   logic [7:0]    wdata_q;
   logic          sel;
   logic          timed_out;
   logic          unused_status;

   // The master's phase flags are informational; sequencing relies on the pulses alone.
   assign unused_status = m_send ^ m_receive;

   // On a tie the requester that did not win last time is chosen.
   assign sel       = req_valid[1] & (~req_valid[0] | ~last);
   assign timed_out = (timer == TW'(TIMEOUT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last       <= 1'b1;
         err        <= 1'b0;
         timer      <= '0;
         dev_q      <= '0;
         rw_q       <= 1'b0;
         reg_q      <= '0;
         wdata_q    <= '0;
         grant      <= '0;
         req_done   <= '0;
         req_err    <= '0;
         rdata      <= '0;
         busy       <= 1'b0;
         m_start    <= 1'b0;
         m_datasend <= '0;
      end else begin
         m_start  <= 1'b0;
         req_done <= '0;
         req_err  <= '0;
         case (state)
            IDLE: begin
               if ((|req_valid) && m_ready) begin
                  dev_q   <= sel ? req_dev[13:7]   : req_dev[6:0];
                  rw_q    <= sel ? req_rw[1]       : req_rw[0];
                  reg_q   <= sel ? req_reg[15:8]   : req_reg[7:0];
                  wdata_q <= sel ? req_wdata[15:8] : req_wdata[7:0];
                  grant   <= sel ? 2'b10 : 2'b01;
                  busy    <= 1'b1;
                  last    <= sel;
                  state   <= START;
               end
            end
            START: begin
               // Holding here if the master went busy keeps start away from a non-idle engine.
               if (m_ready) begin
                  m_start    <= 1'b1;
                  m_datasend <= {dev_q, rw_q};
                  timer      <= '0;
                  state      <= ADDR;
               end
            end
            ADDR, REG: begin
               if (m_received) begin
                  err   <= 1'b1;
                  state <= RECOVER;
               end else if (m_sended) begin
                  timer <= '0;
                  if (state == ADDR) begin
                     m_datasend <= reg_q;
                     state      <= REG;
                  end else begin
                     if (!rw_q)
                        m_datasend <= wdata_q;
                     state <= DATA;
                  end
               end else if (timed_out) begin
                  err   <= 1'b1;
                  state <= RECOVER;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DATA: begin
               if (rw_q ? m_sended : m_received) begin
                  err   <= 1'b1;
                  state <= RECOVER;
               end else if (rw_q ? m_received : m_sended) begin
                  if (rw_q)
                     rdata <= m_datareceive;
                  timer <= '0;
                  state <= STOP;
               end else if (timed_out) begin
                  err   <= 1'b1;
                  state <= RECOVER;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            STOP: begin
               if (m_ready) begin
                  req_done <= grant;
                  state    <= DONE;
               end else if (m_sended || m_received) begin
                  timer <= '0;
               end else if (timed_out) begin
                  err   <= 1'b1;
                  state <= RECOVER;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RECOVER: begin
               if (m_ready) begin
                  req_done <= grant;
                  req_err  <= grant & {2{err}};
                  state    <= DONE;
               end
            end
            DONE: begin
               grant <= '0;
               busy  <= 1'b0;
               err   <= 1'b0;
               timer <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - directed self-checking bench for i2c_bus_arbiter
module tb_i2c_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_rw;
   logic [13:0] req_dev;
   logic [15:0] req_reg, req_wdata;
   logic [1:0]  grant, req_done, req_err;
   logic [7:0]  rdata;
   logic        busy, m_start;
   logic        m_ready, m_send, m_sended, m_receive, m_received;
   logic [7:0]  m_datasend, m_datareceive;

   int checks = 0;
   int errors = 0;

   i2c_bus_arbiter #(.TIMEOUT(20), .TW(5)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_rw(req_rw), .req_dev(req_dev),
      .req_reg(req_reg), .req_wdata(req_wdata),
      .grant(grant), .req_done(req_done), .req_err(req_err),
      .rdata(rdata), .busy(busy), .m_start(m_start),
      .m_ready(m_ready), .m_send(m_send), .m_sended(m_sended),
      .m_receive(m_receive), .m_received(m_received),
      .m_datasend(m_datasend), .m_datareceive(m_datareceive)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Master engine model: one transaction from start to done, capturing every byte it is asked to send.
   task automatic serve(input bit is_read, input logic [7:0] rbyte,
                        output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2,
                        output logic [1:0] done, output logic [1:0] err, output bit ok);
      ok = 1'b0; b0 = '0; b1 = '0; b2 = '0; done = '0; err = '0;
      for (int i = 0; i < 20 && !m_start; i++) @(negedge clk);
      if (!m_start) return;
      m_ready  = 1'b0;
      b0       = m_datasend;
      m_sended = 1'b1;
      @(negedge clk);
      m_sended = 1'b0;
      @(negedge clk);
      b1       = m_datasend;
      m_sended = 1'b1;
      @(negedge clk);
      m_sended = 1'b0;
      @(negedge clk);
      if (is_read) begin
         m_datareceive = rbyte;
         m_received    = 1'b1;
      end else begin
         b2       = m_datasend;
         m_sended = 1'b1;
      end
      @(negedge clk);
      m_sended   = 1'b0;
      m_received = 1'b0;
      @(negedge clk);
      m_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (|req_done) begin
            done = req_done;
            err  = req_err;
            ok   = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({grant, req_done, req_err, busy, m_start} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000000", {grant, req_done, req_err, busy, m_start});
      end
      checks++;
      if ({rdata, m_datasend} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0000", {rdata, m_datasend});
      end
   endtask

   task automatic test_write();
      logic [7:0] b0, b1, b2;
      logic [1:0] d, e;
      bit ok;
      req_valid = 2'b01; req_rw = 2'b00;
      req_dev = {7'h00, 7'h77}; req_reg = 16'h00F4; req_wdata = 16'h002E;
      @(negedge clk);
      checks++;
      if ({grant, busy, m_start} !== 4'b0110) begin
         errors++;
         $display("FAIL write_grant: got %b expected 0110", {grant, busy, m_start});
      end
      @(negedge clk);
      checks++;
      if (m_start !== 1'b1) begin
         errors++;
         $display("FAIL write_start_latency: got %b expected 1", m_start);
      end
      serve(1'b0, 8'h00, b0, b1, b2, d, e, ok);
      req_valid = 2'b00;
      checks++;
      if ({ok, b0, b1, b2} !== {1'b1, 24'hEEF42E}) begin
         errors++;
         $display("FAIL write_bytes: got %b %h %h %h expected 1 ee f4 2e", ok, b0, b1, b2);
      end
      checks++;
      if ({d, e} !== 4'b0100) begin
         errors++;
         $display("FAIL write_done: got done=%b err=%b expected done=01 err=00", d, e);
      end
      @(negedge clk);
      checks++;
      if ({grant, busy, req_done} !== 5'b00000) begin
         errors++;
         $display("FAIL write_release: got %b expected 00000", {grant, busy, req_done});
      end
   endtask

   task automatic test_read();
      logic [7:0] b0, b1, b2;
      logic [1:0] d, e;
      bit ok;
      req_valid = 2'b10; req_rw = 2'b10;
      req_dev = {7'h77, 7'h00}; req_reg = 16'hD000; req_wdata = 16'h0000;
      @(negedge clk);
      checks++;
      if (grant !== 2'b10) begin
         errors++;
         $display("FAIL read_grant: got %b expected 10", grant);
      end
      serve(1'b1, 8'h55, b0, b1, b2, d, e, ok);
      req_valid = 2'b00;
      checks++;
      if ({ok, b0, b1} !== {1'b1, 16'hEFD0}) begin
         errors++;
         $display("FAIL read_bytes: got %b %h %h expected 1 ef d0", ok, b0, b1);
      end
      checks++;
      if ({d, e, rdata} !== {4'b1000, 8'h55}) begin
         errors++;
         $display("FAIL read_done: got done=%b err=%b rdata=%h expected 10 00 55", d, e, rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_protocol_error();
      req_valid = 2'b10; req_rw = 2'b10;
      req_dev = {7'h10, 7'h00}; req_reg = 16'h2000;
      for (int i = 0; i < 20 && !m_start; i++) @(negedge clk);
      checks++;
      if (m_start !== 1'b1) begin
         errors++;
         $display("FAIL proto_start: got %b expected 1", m_start);
      end
      m_ready = 1'b0;
      m_datareceive = 8'hAA;
      m_received = 1'b1;
      @(negedge clk);
      m_received = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, req_done} !== 3'b100) begin
         errors++;
         $display("FAIL proto_recover_wait: got %b expected 100", {busy, req_done});
      end
      m_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_done, req_err, rdata} !== {4'b1010, 8'h55}) begin
         errors++;
         $display("FAIL proto_done: got done=%b err=%b rdata=%h expected 10 10 55", req_done, req_err, rdata);
      end
      req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL proto_busy_clear: got %b expected 0", busy);
      end
   endtask

   task automatic test_timeout();
      int nstart;
      nstart = 0;
      req_valid = 2'b01; req_rw = 2'b00;
      req_dev = {7'h00, 7'h12}; req_reg = 16'h0034; req_wdata = 16'h0056;
      for (int i = 0; i < 20 && !m_start; i++) @(negedge clk);
      m_ready = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         if (m_start) nstart++;
         if (k == 5) m_ready = 1'b1;
         if (k == 21) begin
            checks++;
            if (req_done !== 2'b00) begin
               errors++;
               $display("FAIL timeout_early: got done=%b expected 00 at cycle 21", req_done);
            end
         end
         if (k == 22) begin
            checks++;
            if ({req_done, req_err} !== 4'b0101) begin
               errors++;
               $display("FAIL timeout_done: got done=%b err=%b expected 01 01", req_done, req_err);
            end
         end
      end
      checks++;
      if (nstart !== 0) begin
         errors++;
         $display("FAIL timeout_restart: got %0d extra starts expected 0", nstart);
      end
      req_valid = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] b0, b1, b2;
      logic [1:0] d, e;
      bit ok;
      do_reset();
      req_valid = 2'b11; req_rw = 2'b00;
      req_dev = {7'h22, 7'h11}; req_reg = 16'hBBAA; req_wdata = 16'h2211;
      @(negedge clk);
      checks++;
      if (grant !== 2'b01) begin
         errors++;
         $display("FAIL tie_first: got %b expected 01", grant);
      end
      serve(1'b0, 8'h00, b0, b1, b2, d, e, ok);
      req_valid = 2'b10;
      checks++;
      if ({ok, d, b0, b2} !== {3'b101, 8'h22, 8'h11}) begin
         errors++;
         $display("FAIL tie_first_done: got %b %b %h %h expected 1 01 22 11", ok, d, b0, b2);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (grant !== 2'b10) begin
         errors++;
         $display("FAIL tie_second: got %b expected 10", grant);
      end
      serve(1'b0, 8'h00, b0, b1, b2, d, e, ok);
      req_valid = 2'b11;
      checks++;
      if ({ok, d, b0, b2} !== {3'b110, 8'h44, 8'h22}) begin
         errors++;
         $display("FAIL tie_second_done: got %b %b %h %h expected 1 10 44 22", ok, d, b0, b2);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (grant !== 2'b01) begin
         errors++;
         $display("FAIL tie_again: got %b expected 01", grant);
      end
      serve(1'b0, 8'h00, b0, b1, b2, d, e, ok);
      repeat (2) @(negedge clk);
      checks++;
      if (grant !== 2'b10) begin
         errors++;
         $display("FAIL tie_alternate: got %b expected 10", grant);
      end
      serve(1'b0, 8'h00, b0, b1, b2, d, e, ok);
      req_valid = 2'b00;
      checks++;
      if ({ok, d, e} !== 5'b11000) begin
         errors++;
         $display("FAIL tie_alternate_done: got %b %b %b expected 1 10 00", ok, d, e);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [7:0] b0, b1, b2;
      logic [1:0] d, e;
      bit ok;
      req_valid = 2'b01; req_rw = 2'b00;
      req_dev = {7'h22, 7'h77}; req_reg = 16'h33F4; req_wdata = 16'h442E;
      for (int i = 0; i < 20 && !m_start; i++) @(negedge clk);
      m_ready  = 1'b0;
      m_sended = 1'b1;
      @(negedge clk);
      m_sended  = 1'b0;
      req_valid = 2'b11;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({grant, req_done, req_err, busy, m_start, rdata, m_datasend} !== 24'h000000) begin
         errors++;
         $display("FAIL reset_mid: got %h expected 000000",
                  {grant, req_done, req_err, busy, m_start, rdata, m_datasend});
      end
      @(negedge clk);
      reset = 1'b1;
      req_valid = 2'b10;
      m_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (grant !== 2'b10) begin
         errors++;
         $display("FAIL reset_mid_regrant: got %b expected 10", grant);
      end
      serve(1'b0, 8'h00, b0, b1, b2, d, e, ok);
      req_valid = 2'b00;
      checks++;
      if ({ok, d, e, b0, b1, b2} !== {5'b11000, 24'h443344}) begin
         errors++;
         $display("FAIL reset_mid_serve: got %b %b %b %h %h %h expected 1 10 00 44 33 44", ok, d, e, b0, b1, b2);
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      req_valid = '0; req_rw = '0; req_dev = '0; req_reg = '0; req_wdata = '0;
      m_ready = 1'b1; m_send = 1'b0; m_sended = 1'b0;
      m_receive = 1'b0; m_received = 1'b0; m_datareceive = '0;
      test_reset();
      test_write();
      test_read();
      test_protocol_error();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
